// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared codes for the scalar-multiply controller and ecc_k.
//   k_op codes   : K_SET_K, K_SET_U1, K_SET_U2, K_NEXT
//   pt_op codes  : PT_COPY (R=P), PT_DBL (R=2R), PT_ADD (R=R+P)
//   state_t      : controller state encoding
package ecc_pkg;

   localparam logic [1:0] K_SET_K  = 2'b00;
   localparam logic [1:0] K_SET_U1 = 2'b01;
   localparam logic [1:0] K_SET_U2 = 2'b10;
   localparam logic [1:0] K_NEXT   = 2'b11;

   localparam logic [1:0] PT_COPY  = 2'b00;
   localparam logic [1:0] PT_DBL   = 2'b01;
   localparam logic [1:0] PT_ADD   = 2'b10;

   // Scalar-select value that has no ecc_k load command behind it.
   localparam logic [1:0] MODE_BAD = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_WAITK,
      S_COPY,
      S_CHK,
      S_SHIFT,
      S_DBL,
      S_TST,
      S_ADD,
      S_CLR,
      S_DONE
   } state_t;

endpackage

// File: rtl/ecc_pmul_ctrl.sv
// ecc_pmul_ctrl -- sequencer for left-to-right double-and-add point
// multiplication. Loads a scalar into ecc_k, waits for it to normalise,
// then walks the scalar bits issuing COPY/DBL/ADD commands to the point unit.
//   clk, rst            : clock, async active-high reset
//   start, mode, abort  : request, scalar select (00 K, 01 U1, 10 U2), cancel
//   k_rdy, flg_ec_add, flg_ec_last : status from ecc_k
//   k_op, k_en, k_clr   : commands to ecc_k
//   pt_op, pt_start, pt_clr, pt_done : point-unit handshake
//   busy, done, err     : status (done/err are one-cycle pulses)
//   n_dbl, n_add        : DBL/ADD commands issued in the current/last operation
module ecc_pmul_ctrl
   import ecc_pkg::*;
#(
   parameter int TMO_CYC = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       abort,
   input  logic       k_rdy,
   input  logic       flg_ec_add,
   input  logic       flg_ec_last,
   output logic [1:0] k_op,
   output logic       k_en,
   output logic       k_clr,
   output logic [1:0] pt_op,
   output logic       pt_start,
   output logic       pt_clr,
   input  logic       pt_done,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [8:0] n_dbl,
   output logic [8:0] n_add
);

   localparam int TW = $clog2(TMO_CYC + 1);

   state_t        state;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tmo_cnt  <= '0;
         k_op     <= K_SET_K;
         k_en     <= 1'b0;
         k_clr    <= 1'b0;
         pt_op    <= PT_COPY;
         pt_start <= 1'b0;
         pt_clr   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         n_dbl    <= '0;
         n_add    <= '0;
      end else begin
         // NOTE: state and outputs are registers, so every assignment here is
         // non-blocking; the pulse outputs default low so each assertion
         // below lasts exactly one clock.
         k_en     <= 1'b0;
         k_clr    <= 1'b0;
         pt_start <= 1'b0;
         pt_clr   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;

         if (state != S_IDLE && abort) begin
            // Abort outranks pt_done and any other transition this cycle.
            state   <= S_IDLE;
            tmo_cnt <= '0;
            k_clr   <= 1'b1;
            pt_clr  <= 1'b1;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (mode == MODE_BAD) begin
                        err <= 1'b1;
                     end else if (k_rdy) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        n_dbl <= '0;
                        n_add <= '0;
                        k_en  <= 1'b1;
                        k_op  <= mode;   // mode codes equal SET_K/U1/U2
                     end
                  end
               end

               S_LOAD: begin
                  // tmo_cnt equals the number of cycles since LOAD.
                  state   <= S_WAITK;
                  tmo_cnt <= TW'(1);
               end

               S_WAITK: begin
                  if (k_rdy) begin
                     state    <= S_COPY;
                     tmo_cnt  <= '0;
                     pt_start <= 1'b1;
                     pt_op    <= PT_COPY;
                  end else if (tmo_cnt >= TW'(TMO_CYC - 1)) begin
                     // A zero scalar never normalises; err lands TMO_CYC
                     // cycles after LOAD.
                     state   <= S_IDLE;
                     tmo_cnt <= '0;
                     err     <= 1'b1;
                     k_clr   <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end

               S_COPY: if (pt_done) state <= S_CHK;

               S_CHK: begin
                  if (flg_ec_last) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     k_clr <= 1'b1;
                  end else begin
                     state <= S_SHIFT;
                     k_en  <= 1'b1;
                     k_op  <= K_NEXT;
                     n_dbl <= n_dbl + 9'd1;
                  end
               end

               S_SHIFT: begin
                  state    <= S_DBL;
                  pt_start <= 1'b1;
                  pt_op    <= PT_DBL;
               end

               S_DBL: if (pt_done) state <= S_TST;

               S_TST: begin
                  if (flg_ec_add) begin
                     state    <= S_ADD;
                     pt_start <= 1'b1;
                     pt_op    <= PT_ADD;
                     n_add    <= n_add + 9'd1;
                  end else begin
                     state <= S_CHK;
                  end
               end

               S_ADD: begin
                  if (pt_done) begin
                     // NEXT from CLR clears the bit just consumed by ADD.
                     state <= S_CLR;
                     k_en  <= 1'b1;
                     k_op  <= K_NEXT;
                  end
               end

               S_CLR: state <= S_CHK;

               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ecc_pmul_ctrl.md
ECC_PMUL_CTRL -- requirements
Module: ecc_pmul_ctrl

Interface
REQ-001 Parameter: TMO_CYC, default 300, cycle limit for ecc_k scalar normalisation before error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 start  input  1  one-cycle request; ignored while busy=1.
REQ-005 mode  input  2  scalar select, latched on accepted start: 00 K, 01 U1, 10 U2; 11 SHALL be rejected as err.
REQ-006 abort  input  1  cancels the operation in progress.
REQ-007 k_rdy, flg_ec_add, flg_ec_last  input  1 each  status from ecc_k.
REQ-008 k_op  output  2  to ecc_k: 00 SET_K, 01 SET_U1, 10 SET_U2, 11 NEXT.
REQ-009 k_en, k_clr  output  1 each  to ecc_k.
REQ-010 pt_op  output  2  to point unit: 00 COPY (R=P), 01 DBL (R=2R), 10 ADD (R=R+P).
REQ-011 pt_start  output  1  one-cycle command pulse; pt_clr output 1 point-unit cancel pulse.
REQ-012 pt_done  input  1  point-unit completion pulse.
REQ-013 busy, done, err  output  1 each  status; done and err are one-cycle pulses.
REQ-014 n_dbl, n_add  output  9 each  DBL/ADD commands issued in the current/last operation.

Function
REQ-015 States: IDLE, LOAD, WAITK, COPY, CHK, SHIFT, DBL, TST, ADD, CLR, DONE.
REQ-016 IDLE: on start with valid mode and k_rdy=1 -> LOAD; clear n_dbl, n_add; busy=1 from next cycle until the cycle after DONE/err.
REQ-017 LOAD: k_en=1, k_op=mode for exactly one cycle -> WAITK.
REQ-018 WAITK: wait k_rdy=1 -> COPY; if TMO_CYC cycles elapse first -> err pulse, k_clr pulse, IDLE (zero scalar case).
REQ-019 COPY/DBL/ADD: pt_start=1 in the first cycle only; pt_op held stable until pt_done; pt_done exits: COPY->CHK, DBL->TST, ADD->CLR.
REQ-020 CHK: flg_ec_last=1 -> DONE, else -> SHIFT.
REQ-021 SHIFT: k_en=1, k_op=NEXT one cycle; n_dbl+1 -> DBL.
REQ-022 TST: flg_ec_add=1 -> ADD (n_add+1), else -> CHK.
REQ-023 CLR: k_en=1, k_op=NEXT one cycle (clears scanned bit) -> CHK.
REQ-024 DONE: done=1 and k_clr=1 for one cycle -> IDLE.
REQ-025 k_en SHALL never be asserted outside LOAD/SHIFT/CLR; pt_start never while a command is outstanding.
REQ-026 pt_done outside COPY/DBL/ADD SHALL be ignored.
REQ-027 abort in any non-IDLE state: next cycle k_clr=1, pt_clr=1, state IDLE, no done, no err; abort wins over simultaneous pt_done/start.
REQ-028 start with mode=11: err pulse, remain IDLE, no k_en.
REQ-029 n_dbl/n_add SHALL hold their final values in IDLE until next accepted start.

Reset
REQ-030 rst SHALL force IDLE; k_en, k_clr, pt_start, pt_clr, busy, done, err = 0; k_op, pt_op = 00; n_dbl, n_add, timeout counter = 0.
REQ-031 rst mid-operation SHALL abandon it silently; first post-reset start SHALL behave as from power-up.

Structure
REQ-032 Shared package ecc_pkg SHALL hold K_SET_K/K_SET_U1/K_SET_U2/K_NEXT, PT_COPY/PT_DBL/PT_ADD codes and the state encoding.
REQ-033 No sub-module; single FSM plus timeout and n_dbl/n_add counters, instantiated beside ecc_k at core level.

Verification (bench pairs DUT with real ecc_k and a point-unit model, pt_done 3 cycles after pt_start)
REQ-034 scalar K=11 (0b1011), mode=00 -> pt sequence COPY,DBL,DBL,ADD,DBL,ADD; n_dbl=3, n_add=2; one done pulse.
REQ-035 scalar=1 -> COPY only, n_dbl=0, n_add=0, done after COPY.
REQ-036 scalar=2^255 -> 255 DBL, 0 ADD; scalar=2^256-1 -> 255 DBL, 255 ADD.
REQ-037 scalar=0 -> err pulse TMO_CYC cycles after LOAD, k_clr pulse, no pt_start beyond none issued, busy drops.
REQ-038 abort during 5th DBL of K=0xFF -> k_clr and pt_clr next cycle, IDLE, no done; subsequent start with K=11 reproduces REQ-034.
REQ-039 start with mode=11 -> err pulse, busy stays 0; start while busy -> ignored, counts unchanged.
